// File: rtl/sample_dump_pkg.sv
// Shared types and helpers for the sample capture/dump bridge.
// Parser/serializer state encodings and command-byte field positions.
package sample_dump_pkg;

    typedef enum logic [1:0] {
        P_IDLE,
        P_B1,
        P_EXEC
    } p_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BYTE,
        S_WAIT,
        S_TERM
    } s_state_t;

    localparam int CMD_CAPTURE_BIT = 7;
    localparam int CMD_ADDR_MSB    = 3;

    // Bytes needed to carry one channel sample, zero-extended.
    function automatic int bytes_per_ch(input int sample_w);
        return (sample_w + 7) / 8;
    endfunction

endpackage

// File: rtl/dump_fifo.sv
// Synchronous show-ahead FIFO; full is the pre-pop state, so a push into a
// full FIFO is dropped even when a pop happens in the same cycle.
module dump_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         wr_en, rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/sample_dump_bridge.sv
// Host command parser, sample capture into dump_fifo, and byte serializer.
// Define SAMPLE_SEQ_EN to prefix every frame with an 8-bit sample sequence byte.
module sample_dump_bridge
    import sample_dump_pkg::*;
#(
    parameter int         SAMPLE_W   = 16,
    parameter int         CHANNELS   = 2,
    parameter int         FIFO_DEPTH = 64,
    parameter logic [7:0] TERM_BYTE  = 8'h00,
    parameter int         RX_TIMEOUT = 4800
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         smp_stb,
    input  logic [CHANNELS*SAMPLE_W-1:0] smp_dat,
    input  logic                         rx_stb,
    input  logic [7:0]                   rx_dat,
    input  logic                         tx_busy,
    output logic                         tx_start,
    output logic [7:0]                   tx_dat,
    output logic                         reg_we,
    output logic [3:0]                   reg_addr,
    output logic [7:0]                   reg_data,
    output logic                         capturing,
    output logic                         overflow
);

    localparam int BPC = bytes_per_ch(SAMPLE_W);
    localparam int DW  = CHANNELS * SAMPLE_W;
`ifdef SAMPLE_SEQ_EN
    localparam int SEQ_B = 1;
`else
    localparam int SEQ_B = 0;
`endif
    localparam int NB = CHANNELS * BPC + SEQ_B;
    localparam int FW = DW + 8 * SEQ_B;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int IW = $clog2(NB + 1);

    // ---------------- command parser ----------------
    p_state_t    p_state, p_next;
    logic [7:0]  byte0, byte1;
    logic [TW-1:0] to_cnt;
    logic        exec, is_cap;
    logic        unused_cmd_bits;

    assign exec            = (p_state == P_EXEC);
    assign is_cap          = byte0[CMD_CAPTURE_BIT];
    assign unused_cmd_bits = ^byte0[CMD_CAPTURE_BIT-1:CMD_ADDR_MSB+1];

    always_comb begin
        p_next = p_state;
        case (p_state)
            P_IDLE: if (rx_stb) p_next = P_B1;
            P_B1: begin
                if (rx_stb)                             p_next = P_EXEC;
                else if (to_cnt == TW'(RX_TIMEOUT - 1)) p_next = P_IDLE;
            end
            P_EXEC:  p_next = P_IDLE;
            default: p_next = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_state  <= P_IDLE;
            byte0    <= '0;
            byte1    <= '0;
            to_cnt   <= '0;
            reg_we   <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
        end else begin
            p_state <= p_next;
            if (p_state == P_IDLE && rx_stb) byte0 <= rx_dat;
            if (p_state == P_B1 && rx_stb)   byte1 <= rx_dat;
            to_cnt <= (p_state == P_B1) ? to_cnt + TW'(1) : '0;
            reg_we <= exec && !is_cap;
            if (exec && !is_cap) begin
                reg_addr <= byte0[CMD_ADDR_MSB:0];
                reg_data <= byte1;
            end
        end
    end

    // ---------------- capture path ----------------
    logic [8:0]    remaining;
    logic          smp_take;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [FW-1:0] fifo_wr, fifo_rd;

    assign smp_take = capturing && smp_stb && (remaining != 9'd0);

`ifdef SAMPLE_SEQ_EN
    logic [7:0] seq;
    // Dropped samples still advance the sequence so the host can see gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                seq <= '0;
        else if (exec && is_cap) seq <= '0;
        else if (smp_take)       seq <= seq + 8'd1;
    end
    assign fifo_wr = {smp_dat, seq};
`else
    assign fifo_wr = smp_dat;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capturing <= 1'b0;
            remaining <= '0;
            overflow  <= 1'b0;
        end else if (exec && is_cap) begin
            capturing <= 1'b1;
            remaining <= (byte1 == 8'd0) ? 9'd256 : {1'b0, byte1};
            overflow  <= 1'b0;
        end else begin
            if (smp_take)                        remaining <= remaining - 9'd1;
            if (capturing && remaining == 9'd0)  capturing <= 1'b0;
            if (smp_take && fifo_full)           overflow  <= 1'b1;
        end
    end

    dump_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (smp_take),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------- serializer ----------------
    s_state_t              s_state, s_next;
    logic [NB-1:0][7:0]    frame_q, frame_d;
    logic [BPC*8-1:0]      ext;
    logic [IW-1:0]         idx;

    // Frame byte 0 goes out first: channel 0 MSB byte first, zero-extended.
    always_comb begin
        frame_d = '0;
        ext     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ext = '0;
            ext[SAMPLE_W-1:0] = fifo_rd[SEQ_B*8 + c*SAMPLE_W +: SAMPLE_W];
            for (int k = 0; k < BPC; k++)
                frame_d[SEQ_B + c*BPC + k] = ext[8*(BPC-1-k) +: 8];
        end
`ifdef SAMPLE_SEQ_EN
        frame_d[0] = fifo_rd[7:0];
`endif
    end

    // S_WAIT is the guard cycle after each tx_start, since tx_busy rises late.
    always_comb begin
        s_next   = s_state;
        tx_start = 1'b0;
        tx_dat   = 8'h00;
        fifo_pop = 1'b0;
        case (s_state)
            S_IDLE: if (!fifo_empty && !tx_busy) s_next = S_LOAD;
            S_LOAD: begin
                fifo_pop = 1'b1;
                s_next   = S_BYTE;
            end
            S_BYTE: if (!tx_busy) begin
                tx_start = 1'b1;
                tx_dat   = frame_q[0];
                s_next   = S_WAIT;
            end
            S_WAIT: s_next = (idx == IW'(NB)) ? S_TERM : S_BYTE;
            S_TERM: if (!tx_busy) begin
                tx_start = 1'b1;
                tx_dat   = TERM_BYTE;
                s_next   = S_IDLE;
            end
            default: s_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_state <= S_IDLE;
            frame_q <= '0;
            idx     <= '0;
        end else begin
            s_state <= s_next;
            if (s_state == S_LOAD) begin
                frame_q <= frame_d;
                idx     <= '0;
            end else if (s_state == S_BYTE && !tx_busy) begin
                frame_q <= frame_q >> 8;
                idx     <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sample_dump_bridge.sv
// Randomized self-checking bench for sample_dump_bridge with a byte-stream model.
module tb_sample_dump_bridge;

    localparam int SW    = 12;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int RXT   = 40;
    localparam int DW    = SW * CH;
    localparam int BPC   = (SW + 7) / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          smp_stb = 1'b0;
    logic [DW-1:0] smp_dat = '0;
    logic          rx_stb = 1'b0;
    logic [7:0]    rx_dat = 8'h00;
    logic          busy_hold = 1'b0;
    logic          busy_emul = 1'b0;
    wire           tx_busy = busy_hold | busy_emul;
    logic          tx_start;
    logic [7:0]    tx_dat;
    logic          reg_we;
    logic [3:0]    reg_addr;
    logic [7:0]    reg_data;
    logic          capturing;
    logic          overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_len = 3;
    int seq_m = 0;
    int we_cnt = 0;
    logic [3:0] we_addr = '0;
    logic [7:0] we_data = '0;
    byte unsigned got[$];
    byte unsigned exp_q[$];
    int got_t[$];

    sample_dump_bridge #(
        .SAMPLE_W   (SW),
        .CHANNELS   (CH),
        .FIFO_DEPTH (DEPTH),
        .TERM_BYTE  (8'h00),
        .RX_TIMEOUT (RXT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .smp_stb   (smp_stb),
        .smp_dat   (smp_dat),
        .rx_stb    (rx_stb),
        .rx_dat    (rx_dat),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_dat    (tx_dat),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .capturing (capturing),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte and register-write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_start) begin
            got.push_back(tx_dat);
            got_t.push_back(cyc);
        end
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_data;
        end
    end

    // Transmitter emulation: busy rises two edges after tx_start (late), lasts busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                @(posedge clk);
                #1 busy_emul = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 busy_emul = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Expected bytes for one sample frame.
    function automatic void model_frame(input logic [DW-1:0] s);
`ifdef SAMPLE_SEQ_EN
        exp_q.push_back(8'(seq_m));
`endif
        for (int c = 0; c < CH; c++) begin
            int unsigned v;
            v = 32'(s[c*SW +: SW]);
            for (int k = BPC - 1; k >= 0; k--)
                exp_q.push_back(8'((v >> (8 * k)) & 32'hFF));
        end
        exp_q.push_back(8'h00);
    endfunction

    function automatic int first_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got[i] != exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_dat = b;
        rx_stb = 1'b1;
        @(negedge clk);
        rx_stb = 1'b0;
    endtask

    task automatic capture_cmd(input logic [7:0] n);
        send_rx(8'h80 | 8'($urandom_range(0, 127)));
        send_rx(n);
        seq_m = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic strobe(input logic [DW-1:0] s, input bit stored);
        @(negedge clk);
        smp_dat = s;
        smp_stb = 1'b1;
        @(negedge clk);
        smp_stb = 1'b0;
        if (stored) model_frame(s);
        seq_m = (seq_m + 1) % 256;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int i;
        i = 0;
        while (got.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (60) @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_sample();
        return {12'($urandom), 12'($urandom)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0)  begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_dat !== 8'h00)   begin failures++; $display("FAIL reset_tx_dat got=%h exp=00", tx_dat); end
        checks++; if (reg_we !== 1'b0)    begin failures++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
        checks++; if (reg_addr !== 4'h0)  begin failures++; $display("FAIL reset_reg_addr got=%h exp=0", reg_addr); end
        checks++; if (reg_data !== 8'h00) begin failures++; $display("FAIL reset_reg_data got=%h exp=00", reg_data); end
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL reset_capturing got=%b exp=0", capturing); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int base;
        logic [3:0] a;
        logic [7:0] d;
        got.delete();
        base = we_cnt;
        send_rx(8'h05);
        send_rx(8'hA7);
        repeat (4) @(negedge clk);
        checks++; if (we_cnt - base !== 1) begin failures++; $display("FAIL write_pulses got=%0d exp=1", we_cnt - base); end
        checks++; if (we_addr !== 4'h5)    begin failures++; $display("FAIL write_addr got=%h exp=5", we_addr); end
        checks++; if (we_data !== 8'hA7)   begin failures++; $display("FAIL write_data got=%h exp=a7", we_data); end
        checks++; if (got.size() !== 0)    begin failures++; $display("FAIL write_no_tx got=%0d bytes exp=0", got.size()); end
        for (int it = 0; it < 4; it++) begin
            a = 4'($urandom);
            d = 8'($urandom);
            base = we_cnt;
            send_rx({1'b0, 3'($urandom), a});
            send_rx(d);
            repeat (4) @(negedge clk);
            checks++;
            if (we_cnt - base !== 1 || we_addr !== a || we_data !== d) begin
                failures++;
                $display("FAIL write_rand pulses=%0d addr=%h data=%h exp pulses=1 addr=%h data=%h",
                         we_cnt - base, we_addr, we_data, a, d);
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        int d;
        got.delete(); exp_q.delete();
        base = we_cnt;
        send_rx(8'h03);
        repeat (RXT + 1) @(negedge clk);
        send_rx(8'h82);
        send_rx(8'h02);
        seq_m = 0;
        repeat (3) @(negedge clk);
        checks++; if (we_cnt - base !== 0) begin failures++; $display("FAIL timeout_no_write got=%0d exp=0", we_cnt - base); end
        checks++; if (capturing !== 1'b1)  begin failures++; $display("FAIL timeout_capturing got=%b exp=1", capturing); end
        strobe(rnd_sample(), 1'b1);
        repeat (40) @(negedge clk);
        strobe(rnd_sample(), 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (capturing !== 1'b0)  begin failures++; $display("FAIL timeout_cap_end got=%b exp=0", capturing); end
        wait_bytes(exp_q.size(), 2000);
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL timeout_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_basic();
        int d;
        got.delete(); exp_q.delete();
        capture_cmd(8'd2);
        strobe({12'hABC, 12'h123}, 1'b1);
        checks++; if (capturing !== 1'b1) begin failures++; $display("FAIL basic_cap_mid got=%b exp=1", capturing); end
        strobe({12'h001, 12'hFFF}, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL basic_cap_end got=%b exp=0", capturing); end
        wait_bytes(exp_q.size(), 2000);
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL basic_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        int n;
        int d;
        got.delete(); exp_q.delete();
        n = $urandom_range(3, 8);
        capture_cmd(8'(n));
        for (int i = 0; i < n; i++) begin
            strobe(rnd_sample(), 1'b1);
            repeat (40) @(negedge clk);
        end
        strobe(rnd_sample(), 1'b0);
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL random_cap_end got=%b exp=0", capturing); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL random_overflow got=%b exp=0", overflow); end
        wait_bytes(exp_q.size(), 3000);
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL random_stream n=%0d idx=%0d got_n=%0d exp_n=%0d", n, d, got.size(), exp_q.size()); end
    endtask

    task automatic test_overflow();
        int d;
        got.delete(); exp_q.delete();
        busy_hold = 1'b1;
        capture_cmd(8'd6);
        for (int i = 0; i < 6; i++) strobe(rnd_sample(), i < DEPTH);
        repeat (3) @(negedge clk);
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL ovf_cap_end got=%b exp=0", capturing); end
        checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (got.size() !== 0)   begin failures++; $display("FAIL ovf_no_tx got=%0d exp=0", got.size()); end
        busy_hold = 1'b0;
        wait_bytes(exp_q.size(), 3000);
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL ovf_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), exp_q.size()); end
        got.delete(); exp_q.delete();
        capture_cmd(8'd1);
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        strobe(rnd_sample(), 1'b1);
        wait_bytes(exp_q.size(), 2000);
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL ovf_after_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_count_256();
        int d;
        got.delete(); exp_q.delete();
        busy_hold = 1'b1;
        capture_cmd(8'd0);
        for (int i = 0; i < 255; i++) strobe(rnd_sample(), i < DEPTH);
        repeat (2) @(negedge clk);
        checks++; if (capturing !== 1'b1) begin failures++; $display("FAIL cnt256_still got=%b exp=1", capturing); end
        strobe(rnd_sample(), 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL cnt256_end got=%b exp=0", capturing); end
        checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL cnt256_ovf got=%b exp=1", overflow); end
        busy_hold = 1'b0;
        wait_bytes(exp_q.size(), 3000);
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL cnt256_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_handshake();
        int d;
        got.delete(); got_t.delete(); exp_q.delete();
        busy_len = 48;
        capture_cmd(8'd1);
        strobe(rnd_sample(), 1'b1);
        wait_bytes(exp_q.size(), 1500);
        d = first_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL hs_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), exp_q.size()); end
        for (int i = 1; i < got_t.size(); i++) begin
            checks++;
            if (got_t[i] - got_t[i-1] < 50) begin
                failures++;
                $display("FAIL hs_spacing byte=%0d gap=%0d exp>=50", i, got_t[i] - got_t[i-1]);
            end
        end
        busy_len = 3;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int i;
        got.delete(); exp_q.delete();
        busy_len = 10;
        send_rx(8'h0C);
        send_rx(8'h5A);
        capture_cmd(8'd3);
        strobe(rnd_sample(), 1'b1);
        i = 0;
        while (got.size() < 2 && i < 500) begin @(negedge clk); i++; end
        checks++; if (got.size() < 2) begin failures++; $display("FAIL rmid_start got=%0d bytes exp>=2", got.size()); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx_start !== 1'b0 || tx_dat !== 8'h00 || reg_we !== 1'b0 || reg_addr !== 4'h0 ||
            reg_data !== 8'h00 || capturing !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rmid_outputs tx_start=%b tx_dat=%h reg_we=%b addr=%h data=%h cap=%b ovf=%b exp all 0",
                     tx_start, tx_dat, reg_we, reg_addr, reg_data, capturing, overflow);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        got.delete();
        strobe(rnd_sample(), 1'b0);
        repeat (300) @(negedge clk);
        checks++; if (got.size() !== 0)   begin failures++; $display("FAIL rmid_residual got=%0d bytes exp=0", got.size()); end
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL rmid_capturing got=%b exp=0", capturing); end
        busy_len = 3;
    endtask

    initial begin
        test_reset();
        test_write();
        test_timeout();
        test_basic();
        test_random();
        test_random();
        test_overflow();
        test_count_256();
        test_handshake();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
